sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags.sv | 80 ++++++++
 tb/tb_sync_fifo_flags.sv | 104 ++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy, threshold flags, flush, sticky errors and optional FWFT read
module sync_fifo_flags #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 4,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  rd_ok, wr_ok;

    // Acceptance: a write into a full FIFO is allowed when a pop frees a slot in the same cycle
    always_comb begin
        rd_ok   = rd_en && !empty;
        wr_ok   = wr_en && (!full || rd_ok);
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    // Storage is never cleared; reset and flush only suppress the write
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_ok)
            mem_q[wr_ptr_q] <= data_in;
    end

    // Pointers, occupancy and sticky error flags; reset and flush both clear them
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + AW'(wr_ok);
            rd_ptr_q    <= rd_ptr_q + AW'(rd_ok);
            count_q     <= count_d;
            overflow_q  <= overflow_q  | (wr_en && !wr_ok);
            underflow_q <= underflow_q | (rd_en && !rd_ok);
        end
    end

    // Registered read word: nonblocking read of the old entry gives read-before-write on a shared address
    always_ff @(posedge clk) begin
        if (reset)
            dout_q <= '0;
        else if (!flush && rd_ok)
            dout_q <= mem_q[rd_ptr_q];
    end

    assign data_out     = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;
    assign count        = count_q;
    assign full         = count_q == CW'(FIFO_DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= CW'(AF_THRESH);
    assign almost_empty = count_q <= CW'(AE_THRESH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed and random checks of both read modes against a queue-based model
module tb_sync_fifo_flags;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;

    logic       clk = 1'b0;
    logic       reset, flush, wr_en, rd_en;
    logic [7:0] data_in;
    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_udf;

    sync_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(udf0));

    sync_fifo_flags #(.FIFO_WIDTH(8), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(udf1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic f, input logic rs);
        bit rd_ok, wr_ok;
        int n;
        reset = rs; flush = f; wr_en = w; rd_en = r; data_in = d;
        @(posedge clk);
        if (rs) begin
            q.delete(); m_ovf = 0; m_udf = 0; m_dout = 8'h00;
        end else if (f) begin
            q.delete(); m_ovf = 0; m_udf = 0;
        end else begin
            rd_ok = r && q.size() > 0;
            wr_ok = w && (q.size() < D || rd_ok);
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
            if (w && !wr_ok) m_ovf = 1;
            if (r && !rd_ok) m_udf = 1;
        end
        #1;
        n = q.size();
        chk("count",        32'(cnt0), 32'(n));
        chk("full",         32'(full0), 32'(n == D));
        chk("empty",        32'(empty0), 32'(n == 0));
        chk("almost_full",  32'(af0), 32'(n >= AF));
        chk("almost_empty", 32'(ae0), 32'(n <= AE));
        chk("overflow",     32'(ovf0), 32'(m_ovf));
        chk("underflow",    32'(udf0), 32'(m_udf));
        chk("data_out",     32'(dout0), 32'(m_dout));
        chk("fwft_count",   32'(cnt1), 32'(n));
        chk("fwft_flags",   32'({full1, empty1, af1, ae1, ovf1, udf1}),
                            32'({n == D, n == 0, n >= AF, n <= AE, m_ovf, m_udf}));
        if (n > 0) chk("fwft_head", 32'(dout1), 32'(q[0]));
    endtask

    initial begin
        reset = 1; flush = 0; wr_en = 0; rd_en = 0; data_in = 0;
        m_dout = 0; m_ovf = 0; m_udf = 0;
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 0, 8'h11, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h20 + i), 0, 0);
        step(1, 1, 8'hAA, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);
        step(1, 1, 8'h33, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'h5A, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h70 + i), 0, 0);
        step(1, 0, 8'h77, 0, 1);
        step(1, 1, 8'h78, 1, 0);
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 8'($urandom),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) == 0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
